// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts the 1s on a stochastic bitstream over a fixed
// window of STREAM_LEN cycles and presents the total with a valid/ready
// output handshake. The bit present on the start edge is not counted; the
// window covers the STREAM_LEN edges that follow it.
module sc_stream_decoder #(
    parameter int STREAM_LEN = 256,
    parameter int CNT_WIDTH  = $clog2(STREAM_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Sample-counter value at which the current edge takes the final sample.
    localparam logic [CNT_WIDTH-1:0] LAST_SMP = CNT_WIDTH'(STREAM_LEN - 1);

    logic [1:0]           state_q,     state_d;
    logic [CNT_WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_WIDTH-1:0] smp_q,       smp_d;
    logic [CNT_WIDTH-1:0] count_q,     count_d;
    logic                 busy_q,      busy_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] sum_s;

    // Running total including the bit sampled on this edge.
    always_comb begin
        sum_s = acc_q + {{(CNT_WIDTH-1){1'b0}}, bit_in};
    end

    // Next-state logic for the FSM, accumulator, sample counter and result.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        smp_d   = smp_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = {CNT_WIDTH{1'b0}};
                    smp_d   = {CNT_WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                // start is deliberately ignored while a window is running
                acc_d = sum_s;
                smp_d = smp_q + CNT_WIDTH'(1);
                if (smp_q == LAST_SMP) begin
                    count_d = sum_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        // back-to-back: first sample of the new window is next edge
                        state_d = S_ACCUM;
                        acc_d   = {CNT_WIDTH{1'b0}};
                        smp_d   = {CNT_WIDTH{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // status flags are registered copies of the next-state decode
        busy_d      = (state_d == S_ACCUM);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= {CNT_WIDTH{1'b0}};
            smp_q       <= {CNT_WIDTH{1'b0}};
            count_q     <= {CNT_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            smp_q       <= smp_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed self-checking bench for sc_stream_decoder with STREAM_LEN = 16.
`timescale 1ns/1ps
module tb_sc_stream_decoder;

    localparam int SL = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic          bit_in;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;

    int checks;
    int errors;

    sc_stream_decoder #(.STREAM_LEN(SL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle away from the edge before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a window: start accepted at E0 (bit_in = e0_bit there), then
    // pattern[k] is on bit_in at edge E(k+1). start is re-pulsed at edge
    // E(start_at) when start_at > 0. Checks busy/out_valid every cycle and
    // that out_valid rises exactly after E16. Leaves the DUT in DONE.
    task automatic run_window(input logic [15:0] pattern, input logic e0_bit,
                              input int start_at, input string tag);
        start  = 1'b1;
        bit_in = e0_bit;
        tick();                       // E0
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_e0: busy=%b out_valid=%b required busy=1 out_valid=0", tag, busy, out_valid);
        end
        for (int k = 0; k < SL; k++) begin
            bit_in = pattern[k];
            start  = (start_at > 0 && k + 1 == start_at) ? 1'b1 : 1'b0;
            tick();                   // E(k+1)
            start = 1'b0;
            if (k < SL - 1) begin
                checks++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_busy_e%0d: busy=%b out_valid=%b required busy=1 out_valid=0", tag, k + 1, busy, out_valid);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: busy=%b out_valid=%b required busy=0 out_valid=1", tag, busy, out_valid);
        end
    endtask

    // Complete the handshake with start low and confirm a return to IDLE.
    task automatic release_idle(input string tag);
        out_ready = 1'b1;
        start     = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b out_valid=%b required busy=0 out_valid=0", tag, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL reset: busy=%b out_valid=%b count=%0d required 0 0 0", busy, out_valid, count);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_all_ones();
        run_window(16'hFFFF, 1'b1, 0, "ones");
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL ones_count: got %0d expected 16", count);
        end
        release_idle("ones");
    endtask

    task automatic test_zeros_alt();
        run_window(16'h0000, 1'b0, 0, "zeros");
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL zeros_count: got %0d expected 0", count);
        end
        release_idle("zeros");
        run_window(16'h5555, 1'b0, 0, "alt");
        checks++;
        if (count !== 5'd8) begin
            errors++;
            $display("FAIL alt_count: got %0d expected 8", count);
        end
        release_idle("alt");
        run_window(16'h0000, 1'b1, 0, "e0only");
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL e0only_count: got %0d expected 0", count);
        end
        release_idle("e0only");
    endtask

    task automatic test_backpressure();
        run_window(16'h0F0F, 1'b1, 0, "bp");   // 8 ones
        for (int c = 0; c < 10; c++) begin
            out_ready = 1'b0;
            bit_in    = c[0];
            start     = c[0];
            tick();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || count !== 5'd8) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b busy=%b count=%0d required 1 0 8", c, out_valid, busy, count);
            end
        end
        start = 1'b0;
        release_idle("bp");
        checks++;
        if (count !== 5'd8) begin
            errors++;
            $display("FAIL bp_count_kept: got %0d expected 8", count);
        end
    endtask

    task automatic test_start_while_busy();
        run_window(16'hFFFF, 1'b1, 5, "swb");
        checks++;
        if (count !== 5'd16) begin
            errors++;
            $display("FAIL swb_count: got %0d expected 16", count);
        end
        release_idle("swb");
        for (int c = 0; c < 3; c++) begin
            bit_in = 1'b1;
            tick();
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL swb_no_second_%0d: busy=%b out_valid=%b required 0 0", c, busy, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_window(16'hFFFF, 1'b1, 0, "b2b_first");
        out_ready = 1'b1;                      // handshake together with start
        run_window(16'h0FFF, 1'b0, 0, "b2b_second");
        checks++;
        if (count !== 5'd12) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 12", count);
        end
        release_idle("b2b");
    endtask

    task automatic test_reset_mid();
        run_window(16'hFFFF, 1'b1, 0, "rm_prior");
        release_idle("rm_prior");
        start = 1'b1; bit_in = 1'b1;
        tick();                                // E0
        start = 1'b0;
        for (int k = 1; k < 8; k++) tick();    // E1..E7
        rst = 1'b1;
        tick();                                // E8 with reset
        checks++;
        if (count !== 5'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_abort: count=%0d busy=%b out_valid=%b required 0 0 0", count, busy, out_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        run_window(16'h00FF, 1'b1, 0, "rm_new");
        checks++;
        if (count !== 5'd8) begin
            errors++;
            $display("FAIL rm_new_count: got %0d expected 8", count);
        end
        release_idle("rm_new");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_zeros_alt();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary converter that sits directly downstream of the stochastic dot-product stage. It counts the 1s on a single stochastic result bitstream over a fixed window of `STREAM_LEN` clock cycles and presents the total as an unsigned binary count, using a valid/ready output handshake. The count estimates `STREAM_LEN * P(1)`. For a dot-product result this equals `STREAM_LEN * (sum of products) / LENGTH`; rescaling is the consumer's job.

## Interface
Parameters:
- `STREAM_LEN`, default 256: number of bitstream cycles per conversion window; legal range is ≥ 2.
- `CNT_WIDTH`, default `clogb2(STREAM_LEN+1)` (9 at the default): width of the count output. Derived; do not override.

Ports:
- `clk` input, 1 bit: the only clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset. Synchronous and active-high.
- `start` input, 1 bit: request a new conversion. Accepted only in IDLE, or in DONE on the same edge as the output handshake.
- `bit_in` input, 1 bit: stochastic bitstream. Normally the registered dot-product `result`.
- `busy` output, 1 bit: high while in ACCUM.
- `out_valid` output, 1 bit: high while in DONE. `count` holds a completed result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `count` output, `CNT_WIDTH` bits: number of 1s seen in the last completed window.

## Operation
- FSM has three states: IDLE, ACCUM and DONE.
- IDLE:
  - `start`=1 at an edge: go to ACCUM, clear the accumulator, clear the sample counter.
  - `start`=0: stay in IDLE.
- ACCUM:
  - On each edge, sample `bit_in`, add it to the accumulator and increment the sample counter.
  - After exactly `STREAM_LEN` samples, load `count` with the final total (accumulator plus the last sample) and go to DONE.
  - `start` is ignored in ACCUM.
- DONE:
  - `out_valid`=1. `count` is stable.
  - `out_ready`=1 and `start`=0: go to IDLE.
  - `out_ready`=1 and `start`=1: go directly to ACCUM. The accumulator and sample counter are cleared, and the new window's first sample is taken on the next edge.
  - `out_ready`=0: hold. `count` does not change and `start` is ignored.
- Accumulator and `count` are unsigned and `CNT_WIDTH` bits wide. The maximum value is `STREAM_LEN`, so overflow is impossible.
- `count` changes only on the ACCUM→DONE edge and on reset. It keeps the last result through IDLE and the following ACCUM.
- Reset values:
  - State = IDLE.
  - `busy`=0, `out_valid`=0, `count`=0.
  - Accumulator = 0, sample counter = 0.
- Reset mid-operation, in any state, aborts the conversion. The next edge with `rst`=0 starts from IDLE. An asserted `start` on that edge is honoured.
- `rst` has priority over all other inputs.

## Timing
- Let E0 be the edge where `start` is accepted.
- `bit_in` is sampled at edges E1 through E`STREAM_LEN`. The value present on `bit_in` at E0 is not counted. This one-cycle offset matches the register stage in the dot product.
- `busy`=1 in the cycles following E0 through E`STREAM_LEN`-1, and falls after E`STREAM_LEN`.
- `out_valid`=1 and the new `count` appear in the cycle after E`STREAM_LEN`. Latency from start to valid is `STREAM_LEN`+1 edges.
- Handshake completes at the first edge where `out_valid`=1 and `out_ready`=1. `out_valid` falls in the following cycle unless a back-to-back start sends the FSM into ACCUM (`out_valid` still falls, `busy` rises).
- Back-to-back throughput is one result per `STREAM_LEN`+1 cycles.
- All outputs are registered and there is no combinational path from input to output.

## Test plan
Run the bench with `STREAM_LEN`=16 (`CNT_WIDTH`=5).
- **All ones:** `bit_in`=1 constantly, pulse `start` → `out_valid` rises 17 edges after start with `count`=16; `out_ready`=1 returns the FSM to IDLE.
- **Zeros and alternating:** `bit_in`=0 → `count`=0. `bit_in` toggling 1,0,1,0,… starting at E1 → `count`=8. Also drive `bit_in`=1 only at E0 and 0 afterwards → `count`=0, which checks the sample offset.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after valid while toggling `bit_in` and pulsing `start` → `count` and `out_valid` stay stable and no new conversion starts; `out_ready`=1 releases the FSM to IDLE.
- **Start while busy:** pulse `start` at E5 during ACCUM with `bit_in`=1 → single result `count`=16 at the normal time; no second conversion follows.
- **Back-to-back:** assert `start` together with `out_ready` in DONE, with a second stream of twelve 1s then four 0s → `busy` rises immediately; the second result is `count`=12, valid 17 edges after the handshake edge.
- **Reset mid-operation:** assert `rst` at E8 of a conversion with prior `count`=16 → `count`=0, `busy`=0, `out_valid`=0 next cycle. A new start then completes normally with the correct count.
